hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS pipeline.
- Drives the ID/EX bubble (Stall), PC and IF/ID write enables, the IF/ID flush, and a global pipeline freeze. It arbitrates three hazard sources:
  - load-use data hazard,
  - taken branch resolved in EX,
  - multi-cycle data-memory access in MEM.
- Keeps saturating event counters and a sticky memory-timeout error.

Parameters:
- CNT_W, 16, width of each performance counter.
- MEM_TIMEOUT, 64, maximum consecutive not-ready cycles tolerated for one MEM-stage access before the error state.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- IF_ID_Rs  input  5  rs field of the instruction in ID.
- IF_ID_Rt  input  5  rt field of the instruction in ID.
- IF_ID_UsesRt  input  1  the ID instruction reads rt as a source.
- ID_EX_MemRead  input  1  the instruction in EX is a load.
- ID_EX_Rt  input  5  destination of the load in EX.
- EX_BranchTaken  input  1  branch in EX resolved taken this cycle.
- EX_MEM_MemAccess  input  1  the instruction in MEM reads or writes data memory.
- DMemReady  input  1  data memory completes the MEM-stage access this cycle.
- PCWrite  output  1  PC register update enable.
- IF_ID_Write  output  1  IF/ID register update enable.
- IF_ID_Flush  output  1  load a NOP into IF/ID.
- ID_EX_Stall  output  1  load a bubble (all fields zero) into ID/EX.
- PipeFreeze  output  1  hold every pipeline register (PC through MEM/WB).
- StallCount  output  CNT_W  load-use bubbles inserted.
- FlushCount  output  CNT_W  branch flushes performed.
- FreezeCount  output  CNT_W  freeze cycles.
- MemTimeout  output  1  sticky error flag.

Behaviour:
- Detection signals (combinational):
  - loaduse = ID_EX_MemRead & (ID_EX_Rt != 0) & ((ID_EX_Rt == IF_ID_Rs) | (IF_ID_UsesRt & (ID_EX_Rt == IF_ID_Rt))).
  - memwait = EX_MEM_MemAccess & ~DMemReady.
- FSM states:
  - RUN: normal operation.
  - WAIT: freeze in progress; internal wait counter wc, width ceil(log2(MEM_TIMEOUT)) + 1.
  - ERR: terminal.
- RUN transitions:
  - memwait → WAIT, wc = 1.
  - otherwise stay in RUN.
- WAIT transitions:
  - ~memwait → RUN, wc = 0.
  - memwait & wc == MEM_TIMEOUT → ERR, MemTimeout = 1.
  - otherwise wc += 1.
- ERR is left only by rst.
- Outputs, priority freeze > flush > load-use:
  - ERR, or memwait in RUN/WAIT: PipeFreeze = 1, PCWrite = 0, IF_ID_Write = 0, IF_ID_Flush = 0, ID_EX_Stall = 0. Branch and load-use are ignored; inputs are stable because the pipe is held.
  - else if EX_BranchTaken: PCWrite = 1 (target loads), IF_ID_Write = 1, IF_ID_Flush = 1, ID_EX_Stall = 1. Any simultaneous loaduse is discarded, since the ID instruction is squashed.
  - else if loaduse: PCWrite = 0, IF_ID_Write = 0, ID_EX_Stall = 1, IF_ID_Flush = 0. Exactly one bubble results, because the next cycle ID_EX_MemRead is 0.
  - else: PCWrite = 1, IF_ID_Write = 1, all others 0.
- A freeze ends in the cycle DMemReady = 1. In that cycle the pipe advances, and flush/load-use evaluation applies in the same cycle.
- Counters (registered, saturate at all-ones, never wrap):
  - StallCount increments on each cycle with the load-use output case.
  - FlushCount increments on each branch-flush cycle.
  - FreezeCount increments on each PipeFreeze cycle, including ERR.
- Reset:
  - rst asserted at any time (including mid-WAIT) forces immediately: state RUN, wc 0, all counters 0, MemTimeout 0.
  - While rst = 1, outputs are PCWrite 0, IF_ID_Write 0, IF_ID_Flush 1, ID_EX_Stall 1, PipeFreeze 0.
- Latency: hazard outputs are combinational in the same cycle as detection. Counters and MemTimeout reflect an event one cycle after it.

Test Plan:
- Load-use: ID_EX_MemRead = 1, ID_EX_Rt = 8, IF_ID_Rs = 8, one cycle → ID_EX_Stall = 1, PCWrite = 0, IF_ID_Write = 0 for exactly 1 cycle; StallCount = 1. Repeat with ID_EX_Rt = 0 → no stall. Repeat with Rt match and IF_ID_UsesRt = 0 → no stall.
- Branch plus load-use in the same cycle: EX_BranchTaken = 1 with loaduse true → IF_ID_Flush = 1, ID_EX_Stall = 1, PCWrite = 1; FlushCount = 1, StallCount unchanged.
- Memory wait: EX_MEM_MemAccess = 1, DMemReady = 0 for 5 cycles then 1 → PipeFreeze = 1 for 5 cycles and 0 on the ready cycle; FreezeCount = 5; state back to RUN. A branch or load-use asserted during the wait is ignored until the ready cycle.
- Timeout: MEM_TIMEOUT = 4, DMemReady held 0 → enter ERR after 4 WAIT cycles. MemTimeout = 1 stays set and PipeFreeze = 1 persists after DMemReady = 1, until rst.
- Reset mid-WAIT: assert rst asynchronously (off clock edge) during a freeze → counters, MemTimeout and state clear immediately, with outputs at their reset values. After release with no hazard: PCWrite = 1, IF_ID_Write = 1.
- Saturation: CNT_W = 2, 5 consecutive flushes → FlushCount stays at 3.

Source files
------------

// File: rtl/hazard_stall_if.sv
// hazard_stall_if: hazard inputs and stall/flush/freeze outputs between the pipeline and the stall controller
interface hazard_stall_if #(parameter int CNT_W = 16);
  logic [4:0]       IF_ID_Rs;
  logic [4:0]       IF_ID_Rt;
  logic             IF_ID_UsesRt;
  logic             ID_EX_MemRead;
  logic [4:0]       ID_EX_Rt;
  logic             EX_BranchTaken;
  logic             EX_MEM_MemAccess;
  logic             DMemReady;
  logic             PCWrite;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Stall;
  logic             PipeFreeze;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;
  logic [CNT_W-1:0] FreezeCount;
  logic             MemTimeout;
  modport master (
    output IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt, ID_EX_MemRead, ID_EX_Rt,
           EX_BranchTaken, EX_MEM_MemAccess, DMemReady,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Stall, PipeFreeze,
           StallCount, FlushCount, FreezeCount, MemTimeout
  );
  modport slave (
    input  IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt, ID_EX_MemRead, ID_EX_Rt,
           EX_BranchTaken, EX_MEM_MemAccess, DMemReady,
    output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Stall, PipeFreeze,
           StallCount, FlushCount, FreezeCount, MemTimeout
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: 5-stage pipeline hazard arbiter (freeze > flush > load-use) with event counters and memory timeout
module hazard_stall_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input logic           clk,
  input logic           rst,
  hazard_stall_if.slave hz
);
  localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;
  typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;
  state_t           state_q, state_d;
  logic [WC_W-1:0]  wc_q, wc_d;
  logic             mt_q, mt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;
  logic             loaduse, memwait, freeze, flush, stall;
  always_comb begin
    loaduse = hz.ID_EX_MemRead & (hz.ID_EX_Rt != 5'd0) &
              ((hz.ID_EX_Rt == hz.IF_ID_Rs) | (hz.IF_ID_UsesRt & (hz.ID_EX_Rt == hz.IF_ID_Rt)));
    memwait = hz.EX_MEM_MemAccess & ~hz.DMemReady;
    freeze  = (state_q == ERR) | memwait;
    flush   = ~freeze & hz.EX_BranchTaken;
    stall   = ~freeze & ~hz.EX_BranchTaken & loaduse;
    state_d = state_q;
    wc_d    = wc_q;
    mt_d    = mt_q;
    case (state_q)
      RUN: if (memwait) begin
        state_d = WAIT;
        wc_d    = WC_W'(1);
      end
      WAIT: if (!memwait) begin
        state_d = RUN;
        wc_d    = '0;
      end else if (wc_q == WC_W'(MEM_TIMEOUT)) begin
        state_d = ERR;
        mt_d    = 1'b1;
      end else
        wc_d = wc_q + WC_W'(1);
      default: state_d = ERR;
    endcase
    stall_cnt_d  = (stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d  = (flush && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    freeze_cnt_d = (freeze && !(&freeze_cnt_q)) ? freeze_cnt_q + CNT_W'(1) : freeze_cnt_q;
    // reset holds a bubble in ID/EX and a NOP in IF/ID without freezing
    hz.PipeFreeze  = ~rst & freeze;
    hz.PCWrite     = ~rst & ~freeze & ~stall;
    hz.IF_ID_Write = ~rst & ~freeze & ~stall;
    hz.IF_ID_Flush = rst | flush;
    hz.ID_EX_Stall = rst | flush | stall;
    hz.StallCount  = stall_cnt_q;
    hz.FlushCount  = flush_cnt_q;
    hz.FreezeCount = freeze_cnt_q;
    hz.MemTimeout  = mt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      wc_q         <= '0;
      mt_q         <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      wc_q         <= wc_d;
      mt_q         <= mt_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed checks of hazard arbitration, counters, timeout and reset
module tb_hazard_stall_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  hazard_stall_if #(.CNT_W(16)) ia ();
  hazard_stall_if #(.CNT_W(2))  ib ();
  hazard_stall_ctrl #(.CNT_W(16), .MEM_TIMEOUT(64)) dut_a (.clk(clk), .rst(rst), .hz(ia));
  hazard_stall_ctrl #(.CNT_W(2),  .MEM_TIMEOUT(4))  dut_b (.clk(clk), .rst(rst), .hz(ib));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic set_a(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] rt, input logic ur, input logic br,
                       input logic acc, input logic rdy);
    ia.ID_EX_MemRead = mr; ia.ID_EX_Rt = ert; ia.IF_ID_Rs = rs; ia.IF_ID_Rt = rt;
    ia.IF_ID_UsesRt = ur; ia.EX_BranchTaken = br; ia.EX_MEM_MemAccess = acc; ia.DMemReady = rdy;
  endtask
  task automatic set_b(input logic br, input logic acc, input logic rdy);
    ib.ID_EX_MemRead = 1'b0; ib.ID_EX_Rt = 5'd0; ib.IF_ID_Rs = 5'd0; ib.IF_ID_Rt = 5'd0;
    ib.IF_ID_UsesRt = 1'b0; ib.EX_BranchTaken = br; ib.EX_MEM_MemAccess = acc; ib.DMemReady = rdy;
  endtask
  task automatic chk_out(input string tag, input logic [4:0] exp);
    chk({tag, ".pcw"},    ia.PCWrite,     exp[4]);
    chk({tag, ".ifw"},    ia.IF_ID_Write, exp[3]);
    chk({tag, ".flush"},  ia.IF_ID_Flush, exp[2]);
    chk({tag, ".stall"},  ia.ID_EX_Stall, exp[1]);
    chk({tag, ".freeze"}, ia.PipeFreeze,  exp[0]);
  endtask
  initial begin
    rst = 1'b1;
    set_a(0, 0, 0, 0, 0, 0, 0, 0);
    set_b(0, 0, 0);
    cyc();
    cyc();
    chk_out("rst_out", 5'b00110);
    chk("rst_stallcnt", ia.StallCount, 0);
    chk("rst_flushcnt", ia.FlushCount, 0);
    chk("rst_freezecnt", ia.FreezeCount, 0);
    chk("rst_mt", ia.MemTimeout, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_out("idle", 5'b11000);
    cyc();
    set_a(1, 8, 8, 0, 0, 0, 0, 1);
    #1;
    chk_out("loaduse", 5'b00010);
    cyc();
    chk("lu_cnt1", ia.StallCount, 1);
    set_a(0, 8, 8, 0, 0, 0, 0, 1);
    #1;
    chk_out("lu_bubble", 5'b11000);
    cyc();
    chk("lu_cnt_once", ia.StallCount, 1);
    set_a(1, 0, 0, 0, 1, 0, 0, 1);
    #1;
    chk_out("lu_r0", 5'b11000);
    cyc();
    chk("lu_r0_cnt", ia.StallCount, 1);
    set_a(1, 9, 3, 9, 0, 0, 0, 1);
    #1;
    chk_out("lu_rt_unused", 5'b11000);
    ia.IF_ID_UsesRt = 1'b1;
    #1;
    chk_out("lu_rt_used", 5'b00010);
    cyc();
    chk("lu_rt_cnt", ia.StallCount, 2);
    set_a(1, 8, 8, 0, 0, 1, 0, 1);
    #1;
    chk_out("br_lu", 5'b11110);
    cyc();
    chk("br_flushcnt", ia.FlushCount, 1);
    chk("br_stallcnt", ia.StallCount, 2);
    set_a(1, 8, 8, 0, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_out($sformatf("wait%0d", i), 5'b00001);
      cyc();
    end
    chk("wait_freezecnt", ia.FreezeCount, 5);
    chk("wait_stallcnt", ia.StallCount, 2);
    chk("wait_flushcnt", ia.FlushCount, 1);
    ia.DMemReady = 1'b1;
    #1;
    chk_out("ready_br", 5'b11110);
    cyc();
    chk("ready_flushcnt", ia.FlushCount, 2);
    chk("ready_freezecnt", ia.FreezeCount, 5);
    set_a(0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk_out("after_wait", 5'b11000);
    cyc();
    set_a(0, 0, 0, 0, 0, 0, 1, 0);
    cyc();
    cyc();
    cyc();
    chk("rw_freezecnt", ia.FreezeCount, 8);
    #3;
    rst = 1'b1;
    #1;
    chk_out("rw_rst_out", 5'b00110);
    chk("rw_freezecnt0", ia.FreezeCount, 0);
    chk("rw_flushcnt0", ia.FlushCount, 0);
    chk("rw_stallcnt0", ia.StallCount, 0);
    set_a(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_out("rw_release", 5'b11000);
    cyc();
    chk("rw_freezecnt_hold", ia.FreezeCount, 0);
    set_b(0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("to_freeze%0d", i), ib.PipeFreeze, 1);
      chk($sformatf("to_mt%0d", i), ib.MemTimeout, 0);
      cyc();
    end
    chk("to_mt_set", ib.MemTimeout, 1);
    ib.DMemReady = 1'b1;
    ib.EX_BranchTaken = 1'b1;
    #1;
    chk("err_freeze", ib.PipeFreeze, 1);
    chk("err_pcw", ib.PCWrite, 0);
    chk("err_flush", ib.IF_ID_Flush, 0);
    cyc();
    chk("err_mt_sticky", ib.MemTimeout, 1);
    chk("err_freeze_hold", ib.PipeFreeze, 1);
    chk("err_freezecnt_sat", ib.FreezeCount, 3);
    chk("err_flushcnt", ib.FlushCount, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("err_rst_mt", ib.MemTimeout, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("err_rst_freeze", ib.PipeFreeze, 0);
    chk("err_rst_flush", ib.IF_ID_Flush, 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("sat_flush%0d", i), ib.FlushCount, (i < 2) ? i + 1 : 3);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
